// File: rtl/gf_muls_4_masked_pipe_if.sv
// gf_muls_4_masked_pipe_if: valid/ready streaming bus carrying LANES shared-factor operand pairs and products
interface gf_muls_4_masked_pipe_if #(parameter int LANES = 4);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [9*LANES-1:0] in_a, in_b;
  logic [4*LANES-1:0] out_q;
  modport master(output in_valid, in_a, in_b, out_ready, input in_ready, out_valid, out_q);
  modport slave(input in_valid, in_a, in_b, out_ready, output in_ready, out_valid, out_q);
endinterface

// File: rtl/gf_muls_4_masked_pipe.sv
// gf_muls_4_masked_pipe: two-stage masked GF(2^4) multiplier, basis [alpha^8, alpha^2]; GF_MULS_PIPE_ZEROIZE_EN clears idle data registers
module gf_muls_4_masked_pipe #(parameter int LANES = 4) (
  input logic clk,
  input logic rst,
  input logic flush,
  gf_muls_4_masked_pipe_if.slave bus
);
  logic s1_valid, s2_valid, adv1, adv2;
  logic [6*LANES-1:0] s1_d, pp;
  logic [4*LANES-1:0] s2_d, qq;
  function automatic logic [1:0] mul(input logic [2:0] x, input logic [2:0] y);
    logic e;
    e = x[0] & y[0];
    return {(x[2] & y[2]) ^ e, (x[1] & y[1]) ^ e};
  endfunction
  function automatic logic [1:0] mul_scl(input logic [2:0] x, input logic [2:0] y);
    logic e, m;
    e = x[0] & y[0];
    m = x[1] & y[1];
    return {m ^ e, (x[2] & y[2]) ^ m};
  endfunction
  // partial products stay unmixed until after the stage-1 register
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign pp[6*i +: 6] = {mul(bus.in_a[9*i+3 +: 3], bus.in_b[9*i+3 +: 3]),
                           mul(bus.in_a[9*i +: 3], bus.in_b[9*i +: 3]),
                           mul_scl(bus.in_a[9*i+6 +: 3], bus.in_b[9*i+6 +: 3])};
    assign qq[4*i +: 4] = {s1_d[6*i+4 +: 2] ^ s1_d[6*i +: 2], s1_d[6*i+2 +: 2] ^ s1_d[6*i +: 2]};
  end
  assign bus.in_ready = !s1_valid || !s2_valid || bus.out_ready;
  assign adv1 = bus.in_valid && bus.in_ready;
  assign adv2 = s1_valid && (!s2_valid || bus.out_ready);
  assign bus.out_valid = s2_valid;
  assign bus.out_q = s2_d;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= adv1 ? 1'b1 : adv2 ? 1'b0 : s1_valid;
      s2_valid <= adv2 ? 1'b1 : bus.out_ready ? 1'b0 : s2_valid;
    end
  end
`ifdef GF_MULS_PIPE_ZEROIZE_EN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_d <= '0;
      s2_d <= '0;
    end else begin
      s1_d <= adv1 ? pp : adv2 ? '0 : s1_d;
      s2_d <= adv2 ? qq : bus.out_ready ? '0 : s2_d;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_d <= '0;
      s2_d <= '0;
    end else if (!flush) begin
      if (adv1) s1_d <= pp;
      if (adv2) s2_d <= qq;
    end
  end
`endif
endmodule

// File: tb/tb_gf_muls_4_masked_pipe.sv
// tb_gf_muls_4_masked_pipe: randomized scoreboard bench against a nibble-level GF(2^4) product model
module tb_gf_muls_4_masked_pipe;
  localparam int L = 4;
  logic clk = 0, rst = 1, flush = 0;
  bit rmode = 0;
  int vectors = 0, miscompares = 0;
  logic [15:0] exp_q[$];
  gf_muls_4_masked_pipe_if #(.LANES(L)) bus();
  gf_muls_4_masked_pipe #(.LANES(L)) dut(.clk(clk), .rst(rst), .flush(flush), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [1:0] m2(input logic [1:0] x, input logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction
  function automatic logic [1:0] s2(input logic [1:0] x, input logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[0] & y[0]) ^ e, (x[1] & y[1]) ^ (x[0] & y[0])};
  endfunction
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] p;
    p = s2(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]);
    return {m2(a[3:2], b[3:2]) ^ p, m2(a[1:0], b[1:0]) ^ p};
  endfunction
  function automatic logic [8:0] enc(input logic [3:0] n);
    logic [1:0] s;
    s = n[3:2] ^ n[1:0];
    return {s, ^s, n[3:2], ^n[3:2], n[1:0], ^n[1:0]};
  endfunction
  function automatic logic [15:0] model(input logic [35:0] a, input logic [35:0] b);
    logic [15:0] r;
    for (int i = 0; i < L; i++)
      r[4*i +: 4] = gmul({a[9*i+4 +: 2], a[9*i+1 +: 2]}, {b[9*i+4 +: 2], b[9*i+1 +: 2]});
    return r;
  endfunction
  function automatic logic [35:0] enc4(input logic [15:0] n);
    logic [35:0] r;
    for (int i = 0; i < L; i++) r[9*i +: 9] = enc(n[4*i +: 4]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst || flush) exp_q.delete();
    else if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.in_a, bus.in_b));

  always @(negedge clk)
    if (!rst && !flush && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_beat", {31'b0, bus.out_valid}, 0);
      else chk("out_q", {16'b0, bus.out_q}, {16'b0, exp_q.pop_front()});
    end

  always @(posedge clk) begin
    #1;
    if (rmode) bus.out_ready = $urandom_range(0, 9) < 7;
  end

  task automatic send(input logic [35:0] a, input logic [35:0] b, input bit nostall);
    int n = 0;
    bus.in_valid = 1; bus.in_a = a; bus.in_b = b;
    @(negedge clk);
    if (nostall) chk("no_stall", {31'b0, bus.in_ready}, 1);
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.in_ready) chk("send_timeout", {31'b0, bus.in_ready}, 1);
    @(posedge clk); #1;
    bus.in_valid = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic lat(input logic [15:0] an, input logic [15:0] bn, input logic [3:0] q0);
    bus.in_valid = 1; bus.in_a = enc4(an); bus.in_b = enc4(bn);
    @(negedge clk); chk("lat_accept", {31'b0, bus.in_ready}, 1);
    @(posedge clk); #1; bus.in_valid = 0;
    @(negedge clk); chk("lat_c1", {31'b0, bus.out_valid}, 0);
    @(negedge clk); chk("lat_c2", {31'b0, bus.out_valid}, 1);
    chk("lat_q0", {28'b0, bus.out_q[3:0]}, {28'b0, q0});
    @(negedge clk); chk("lat_c3", {31'b0, bus.out_valid}, 0);
  endtask

  task automatic drain();
    int n = 0;
    rmode = 0; bus.out_ready = 1;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 300) begin cyc(1); n++; end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [15:0] hq;
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1;
    cyc(3); rst = 0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 1);
    chk("rst_out_q", {16'b0, bus.out_q}, 0);
    @(posedge clk); #1;
    lat({12'h000, 4'h6}, {12'h000, 4'hD}, 4'h2);
    for (int k = 0; k < 64; k++) begin
      logic [15:0] an, bn;
      logic [7:0] p;
      for (int l = 0; l < L; l++) begin
        p = 8'(k * 4 + l);
        an[4*l +: 4] = p[7:4]; bn[4*l +: 4] = p[3:0];
      end
      send(enc4(an), enc4(bn), 1);
    end
    drain();
    bus.out_ready = 0;
    send(enc4(16'($urandom)), enc4(16'($urandom)), 1);
    send(enc4(16'($urandom)), enc4(16'($urandom)), 1);
    bus.in_valid = 1; bus.in_a = enc4(16'($urandom)); bus.in_b = enc4(16'($urandom));
    @(negedge clk);
    chk("bp_in_ready", {31'b0, bus.in_ready}, 0);
    chk("bp_out_valid", {31'b0, bus.out_valid}, 1);
    hq = bus.out_q;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_q", {16'b0, bus.out_q}, {16'b0, hq});
      chk("bp_hold_valid", {31'b0, bus.out_valid}, 1);
    end
    @(posedge clk); #1; bus.out_ready = 1;
    send(bus.in_a, bus.in_b, 0);
    drain();
    bus.out_ready = 0;
    send(enc4(16'($urandom)), enc4(16'($urandom)), 1);
    send(enc4(16'($urandom)), enc4(16'($urandom)), 1);
    bus.in_valid = 1; flush = 1;
    @(posedge clk); #1; flush = 0; bus.in_valid = 0;
    @(negedge clk);
    chk("flush_out_valid", {31'b0, bus.out_valid}, 0);
    chk("flush_in_ready", {31'b0, bus.in_ready}, 1);
`ifdef GF_MULS_PIPE_ZEROIZE_EN
    chk("flush_out_q", {16'b0, bus.out_q}, 0);
`endif
    @(posedge clk); #1; bus.out_ready = 1;
    cyc(4);
    send(enc4(16'($urandom)), enc4(16'($urandom)), 1);
    send(enc4(16'($urandom)), enc4(16'($urandom)), 1);
    bus.in_valid = 1; rst = 1;
    @(posedge clk); #1; rst = 0; bus.in_valid = 0;
    @(negedge clk);
    chk("mrst_out_valid", {31'b0, bus.out_valid}, 0);
    chk("mrst_in_ready", {31'b0, bus.in_ready}, 1);
    chk("mrst_out_q", {16'b0, bus.out_q}, 0);
    @(posedge clk); #1;
    hq = 16'($urandom);
    lat(hq, 16'h1234, gmul(hq[3:0], 4'h4));
    rmode = 1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) cyc($urandom_range(1, 3));
      send(enc4(16'($urandom)), enc4(16'($urandom)), 0);
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/gf_muls_4_masked_pipe.md
Name: gf_muls_4_masked_pipe

Overview:
- Multi-lane, two-stage pipelined GF(2^4)/GF(2^2) multiplier with shared-factor operands, in the basis [alpha^8, alpha^2].
- Register boundary between partial products and recombination, so glitches from the masked AND terms never reach the combining XOR in the same cycle.
- Valid/ready streaming interface and a synchronous flush.
- Sits between the masked GF(2^4) inverter datapath and the S-box output stage.

Parameters:
- LANES, 4, number of independent GF(2^4) multipliers processed per transfer (must be >= 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline clear; same priority as rst but reset-free.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts the beat this cycle.
- in_a  input  9*LANES  lane i at [9i+8:9i], format {sum[1:0], sum[1]^sum[0], hi[1:0], hi[1]^hi[0], lo[1:0], lo[1]^lo[0]}, where sum = hi^lo.
- in_b  input  9*LANES  same format as in_a.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_q  output  4*LANES  lane i at [4i+3:4i], format {hi[1:0], lo[1:0]} of the product.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- GF(2^2) shared-factor multiply, on x = {x1, x0, x2} and y = {y1, y0, y2}:
  - e = x2&y2
  - product = {(x1&y1)^e, (x0&y0)^e}
- Scaled multiply (by N):
  - e = x2&y2
  - product = {(x0&y0)^e, (x1&y1)^(x0&y0)}
- Per lane:
  - ph = mul(a[5:3], b[5:3])
  - pl = mul(a[2:0], b[2:0])
  - p = mul_scl(a[8:6], b[8:6])
  - q = {ph^p, pl^p}
- Stage 1 registers: s1_valid plus {ph, pl, p} per lane (6 bits/lane). No XOR of partial products happens before this register.
- Stage 2 registers: s2_valid plus q per lane. out_q is driven directly from the stage-2 register; out_valid = s2_valid.
- Advance conditions:
  - adv2 = s1_valid & (!s2_valid | out_ready).
  - adv1 = in_valid & in_ready.
  - in_ready = !s1_valid | !s2_valid | out_ready. This is combinational from out_ready, by design.
- Stage updates:
  - s2 loads on adv2.
  - s2_valid clears when out_ready & !adv2.
  - s1 loads on adv1.
  - s1_valid clears when adv2 & !adv1.
- Latency and throughput: 2 cycles from an accepted input to out_valid. Throughput is 1 beat/cycle with out_ready held high.
- Stall behaviour:
  - With out_valid=1 and out_ready=0, out_q and out_valid hold stable.
  - With both stages full, in_ready=0.
  - No beat is dropped or duplicated.
- Reset/flush:
  - On rst or flush: s1_valid=0, s2_valid=0, out_valid=0, in_ready=1 the following cycle.
  - Data registers reset to 0 on rst. Their flush behaviour is set by the optional feature.
  - A beat presented in the flush cycle is discarded.
  - Reset mid-stream loses all in-flight beats.
- Simultaneous events:
  - rst/flush win over any handshake in the same cycle.
  - A full pipeline with out_ready=1 and in_valid=1 shifts all stages in the same cycle.
- Lanes are fully independent; there is no cross-lane logic.

Optional Feature:
- Macro: GF_MULS_PIPE_ZEROIZE_EN.
- Defined:
  - Any stage data register whose valid is 0 after the edge is loaded with all-zero. This covers bubbles, flush, and drain.
  - out_q reads 0 whenever out_valid=0, so stale masked intermediates never remain in idle registers.
- Undefined:
  - Data registers load only on their advance condition and otherwise hold.
  - out_q is don't-care while out_valid=0.

Test Plan:
- Single beat, LANES=1, a=9'h19D, b=9'h173, out_ready=1 -> out_valid high exactly 2 cycles after acceptance, out_q=4'h2, then out_valid=0.
- Exhaustive stream, LANES=4, all 256 (a,b) value pairs encoded per the format, in_valid and out_ready held high -> 1 result/cycle in order, each matching the reference model; a=0 or b=0 gives q=0.
- Backpressure: out_ready=0 for 5 cycles while feeding 3 beats -> in_ready drops after 2 beats accepted; out_q stable; all 3 results delivered in order after out_ready=1.
- Random valid/ready toggling, 10k beats -> no loss, no duplication, order preserved, values correct.
- flush asserted with 2 beats in flight -> next cycle out_valid=0, in_ready=1; the in-flight results never appear. With GF_MULS_PIPE_ZEROIZE_EN, out_q=0.
- rst asserted mid-stream for 1 cycle -> all valids 0 next cycle, out_q=0; first beat after release has 2-cycle latency.
